// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int WDOG_W          = 16;
    localparam int DEFAULT_NUM_REQ = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_HOLD    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: the first set request after last_owner wins,
// returned both one-hot and as an index.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    int unsigned        cand;
    logic [NUM_REQ-1:0] shifted;
    logic               found;

    // Walk the lanes starting just after last_owner, wrapping without a modulo.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        shifted    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = 32'(last_owner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            shifted = req >> cand;
            if (!found && shifted[0]) begin
                found      = 1'b1;
                winner     = {{(NUM_REQ-1){1'b0}}, 1'b1} << cand;
                winner_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte interface among NUM_REQ
// sources; an owner keeps the transmitter until its last byte or a watchdog abort.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WDOG    = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_busy,
    output logic [7:0]           write_data,
    output logic                 write_en,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 err_abort
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   last_owner, last_owner_n;
    logic [7:0]         data_n;
    logic               last_q, last_n;
    logic [WDOG_W-1:0]  wdog, wdog_n;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   lane_sel;
    logic [7:0]         lane_data;
    logic               lane_last;
    logic               owner_valid;
    logic               abort;

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (req_valid),
        .last_owner (last_owner),
        .winner     (pick),
        .winner_idx (pick_idx)
    );

    assign owner_valid = |(req_valid & grant);
    // In IDLE the winner's lane is latched; otherwise the current owner's lane.
    assign lane_sel    = (state == ST_IDLE) ? pick_idx : owner;

    always_comb begin
        lane_data = '0;
        lane_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (lane_sel == IDX_W'(i)) begin
                lane_data = req_data[8*i +: 8];
                lane_last = req_last[i];
            end
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        owner_n      = owner;
        last_owner_n = last_owner;
        data_n       = write_data;
        last_n       = last_q;
        wdog_n       = (wdog != '0) ? wdog - 1'b1 : wdog;
        abort        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|req_valid) begin
                    grant_n = pick;
                    owner_n = pick_idx;
                    data_n  = lane_data;
                    last_n  = lane_last;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                wdog_n  = WDOG_LOAD;
                state_n = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // A fast core may finish before we ever see tx_busy high.
                if (tx_busy || wdog == '0) begin
                    state_n = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        last_owner_n = owner;
                        grant_n      = '0;
                        state_n      = ST_IDLE;
                    end else if (owner_valid) begin
                        data_n  = lane_data;
                        last_n  = lane_last;
                        state_n = ST_SEND;
                    end else begin
                        wdog_n  = WDOG_LOAD;
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (owner_valid) begin
                    data_n  = lane_data;
                    last_n  = lane_last;
                    state_n = ST_SEND;
                end else if (wdog == '0) begin
                    abort        = 1'b1;
                    last_owner_n = owner;
                    grant_n      = '0;
                    state_n      = ST_IDLE;
                end
            end
            default: begin
                grant_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner      <= LAST_IDX;
            last_owner <= LAST_IDX;
            write_data <= '0;
            last_q     <= 1'b0;
            wdog       <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            write_data <= data_n;
            last_q     <= last_n;
            wdog       <= wdog_n;
        end
    end

    assign write_en  = (state == ST_SEND);
    assign req_ready = grant & {NUM_REQ{write_en}};
    assign busy      = (state != ST_IDLE);
    assign err_abort = abort;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: randomized packets on three lanes, a UART busy model, and a
// packet-level round-robin reference that predicts the byte stream and its pacing.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int WD = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_busy;
    logic [7:0]     write_data;
    logic           write_en;
    logic [N-1:0]   grant;
    logic           busy;
    logic           err_abort;

    uart_tx_arbiter #(.NUM_REQ(N), .WDOG(WD)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_busy    (tx_busy),
        .write_data (write_data),
        .write_en   (write_en),
        .grant      (grant),
        .busy       (busy),
        .err_abort  (err_abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] lane_mem [N][256];
    int         lane_wr  [N];
    int         lane_rd  [N];

    int uart_hold = 10;
    bit uart_tie0 = 1'b0;
    int uart_cnt  = 0;

    int         cyc = 0;
    logic [N-1:0] rdy_seen = '0;
    logic       we_seen = 1'b0;
    int         obs_cnt = 0;
    int         obs_cyc  [1024];
    int         obs_lane [1024];
    logic [7:0] obs_data [1024];
    bit         obs_rdy_ok [1024];
    int         abort_cnt = 0;
    int         abort_cyc = 0;

    int         m_rd [N];
    int         m_lo = N - 1;
    int         exp_lane [$];
    logic [7:0] exp_data [$];
    bit         exp_last [$];
    int         obs_rd = 0;

    function automatic int onehot_index(input logic [N-1:0] g);
        int idx;
        idx = -1;
        for (int i = 0; i < N; i++) begin
            if (g[i] === 1'b1) idx = (idx == -1) ? i : -2;
        end
        return idx;
    endfunction

    always @(negedge clk) begin
        cyc++;
        rdy_seen = req_ready;
        we_seen  = write_en;
        if (reset === 1'b0 && write_en === 1'b1 && obs_cnt < 1024) begin
            obs_cyc[obs_cnt]    = cyc;
            obs_lane[obs_cnt]   = onehot_index(grant);
            obs_data[obs_cnt]   = write_data;
            obs_rdy_ok[obs_cnt] = (req_ready === grant) && $onehot(grant);
            obs_cnt++;
        end
        if (err_abort === 1'b1) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
    end

    // Requester lanes and UART core model, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset === 1'b1) begin
            for (int i = 0; i < N; i++) lane_rd[i] = lane_wr[i];
            uart_cnt = 0;
        end else begin
            for (int i = 0; i < N; i++) if (rdy_seen[i]) lane_rd[i]++;
            if (we_seen && !uart_tie0) uart_cnt = uart_hold;
            else if (uart_cnt > 0) uart_cnt--;
        end
        tx_busy = (uart_cnt > 0);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (lane_rd[i] < lane_wr[i]);
            {req_last[i], req_data[8*i +: 8]} = req_valid[i] ? lane_mem[i][lane_rd[i] % 256] : 9'h0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push_byte(input int lane, input logic [7:0] d, input bit last);
        lane_mem[lane][lane_wr[lane] % 256] = {last, d};
        lane_wr[lane]++;
    endtask

    task automatic push_rand_pkt(input int lane, input int len);
        for (int b = 0; b < len; b++) push_byte(lane, 8'($urandom), b == len - 1);
    endtask

    // Packet-level round robin over everything queued so far; a packet with no
    // last byte is treated as ending where its queued bytes run out (watchdog abort).
    function automatic void model_run();
        bit found;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int ln;
                ln = (m_lo + k) % N;
                if (!found && m_rd[ln] < lane_wr[ln]) begin
                    bit done;
                    done  = 1'b0;
                    found = 1'b1;
                    while (!done && m_rd[ln] < lane_wr[ln]) begin
                        logic [8:0] b;
                        b = lane_mem[ln][m_rd[ln] % 256];
                        exp_lane.push_back(ln);
                        exp_data.push_back(b[7:0]);
                        exp_last.push_back(b[8]);
                        m_rd[ln]++;
                        done = b[8];
                    end
                    m_lo = ln;
                end
            end
        end
    endfunction

    task automatic wait_obs(input int n, input int budget);
        int k;
        k = 0;
        while (obs_cnt < n && k < budget) begin
            step();
            k++;
        end
        check("wait_write_en", 32'(obs_cnt >= n), 1);
    endtask

    task automatic check_stream(input int n);
        int base;
        bit prev_last;
        base      = uart_tie0 ? WD + 3 : uart_hold + 2;
        prev_last = 1'b0;
        wait_obs(obs_rd + n, n * (WD + 12) + 100);
        for (int i = 0; i < n && obs_rd < obs_cnt && exp_lane.size() > 0; i++) begin
            check("byte_lane", obs_lane[obs_rd], exp_lane[0]);
            check("byte_data", 32'(obs_data[obs_rd]), 32'(exp_data[0]));
            check("ready_eq_grant", 32'(obs_rdy_ok[obs_rd]), 1);
            if (i > 0) check("byte_gap", obs_cyc[obs_rd] - obs_cyc[obs_rd-1], base + (prev_last ? 1 : 0));
            prev_last = exp_last[0];
            void'(exp_lane.pop_front());
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
            obs_rd++;
        end
    endtask

    task automatic check_stream_all();
        check_stream(exp_lane.size());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_en"}, 32'(write_en), 0);
        check({tag, "_write_data"}, 32'(write_data), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err_abort"}, 32'(err_abort), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int start, c, a0, n0;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_all_zero("reset");

        // Contention from reset: lanes 0,1,2 together, then 0 and 1 (wrap to 0).
        uart_hold = $urandom_range(1, 6);
        for (int ln = 0; ln < N; ln++) push_rand_pkt(ln, $urandom_range(1, 4));
        model_run();
        start = obs_rd;
        check_stream_all();
        check("contention_first_lane", obs_lane[start], 0);
        push_rand_pkt(1, $urandom_range(1, 4));
        push_rand_pkt(0, $urandom_range(1, 4));
        model_run();
        start = obs_rd;
        check_stream_all();
        check("wrap_first_lane", obs_lane[start], 0);

        // Random rounds: random lane subsets, one or two packets per lane.
        for (int r = 0; r < 6; r++) begin
            int mask;
            uart_hold = $urandom_range(1, 6);
            mask = $urandom_range(1, (1 << N) - 1);
            for (int ln = 0; ln < N; ln++) begin
                if (mask[ln]) begin
                    int np;
                    np = $urandom_range(1, 2);
                    for (int p = 0; p < np; p++) push_rand_pkt(ln, $urandom_range(1, 4));
                end
            end
            model_run();
            check_stream_all();
        end

        // Single packet on lane 0 with a 10-cycle UART.
        uart_hold = 10;
        push_byte(0, 8'hFF, 1'b0);
        push_byte(0, 8'hFF, 1'b0);
        push_byte(0, 8'h12, 1'b0);
        push_byte(0, 8'h0D, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        model_run();
        check_stream_all();
        c = obs_cyc[obs_rd - 1];
        while (cyc < c + uart_hold + 1) step();
        check("single_grant_before_release", 32'(grant), 32'h1);
        check("single_busy_before_release", 32'(busy), 1);
        step();
        check("single_grant_released", 32'(grant), 0);
        check("single_busy_released", 32'(busy), 0);

        // No preemption: lane 0 arrives while lane 1 is mid-packet.
        uart_hold = 4;
        push_rand_pkt(1, 4);
        model_run();
        wait_obs(obs_rd + 2, 200);
        push_rand_pkt(0, 2);
        model_run();
        check_stream_all();

        // Owner stall: lane 2 sends two non-last bytes then goes quiet.
        uart_hold = 3;
        a0 = abort_cnt;
        push_rand_pkt(2, 3);
        lane_wr[2]--;
        model_run();
        check_stream_all();
        c = obs_cyc[obs_rd - 1];
        while (cyc < c + uart_hold + 2 + WD) step();
        check("stall_err_abort", 32'(err_abort), 1);
        check("stall_grant_at_abort", 32'(grant), 32'h4);
        check("stall_abort_cycle", abort_cyc, c + uart_hold + 2 + WD);
        step();
        check("stall_err_abort_drop", 32'(err_abort), 0);
        check("stall_grant_cleared", 32'(grant), 0);
        repeat (5) step();
        check("stall_abort_once", abort_cnt, a0 + 1);
        push_rand_pkt(1, 2);
        push_rand_pkt(0, 2);
        model_run();
        start = obs_rd;
        check_stream_all();
        check("after_abort_first_lane", obs_lane[start], 0);

        // Fast UART: tx_busy never rises, watchdog paces each byte.
        uart_tie0 = 1'b1;
        a0 = abort_cnt;
        push_rand_pkt(0, 3);
        push_rand_pkt(2, 2);
        model_run();
        check_stream_all();
        repeat (5) step();
        check("fast_no_abort", abort_cnt, a0);

        // Reset during WAIT_HI of byte 3.
        push_rand_pkt(1, 5);
        model_run();
        check_stream(3);
        step();
        reset = 1'b1;
        step();
        check_all_zero("midreset");
        reset = 1'b0;
        exp_lane.delete();
        exp_data.delete();
        exp_last.delete();
        for (int ln = 0; ln < N; ln++) m_rd[ln] = lane_wr[ln];
        m_lo = N - 1;
        n0 = obs_cnt;
        repeat (30) step();
        check("midreset_no_write_en", obs_cnt, n0);
        obs_rd = obs_cnt;
        uart_tie0 = 1'b0;
        uart_hold = 2;
        push_rand_pkt(2, 2);
        push_rand_pkt(0, 2);
        model_run();
        start = obs_rd;
        check_stream_all();
        check("midreset_first_lane", obs_lane[start], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART transmitter byte interface (`write_data`/`write_en`, `tx_busy`) among several packet sources, e.g. the target-coordinate frame generator, a status reporter and a command-response path. A granted source keeps the transmitter until it sends a byte flagged `last`, so packets never interleave. The block sits between the packet generators and the UART TX core and paces bytes on `tx_busy` edges, replacing per-source pacing logic.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `WDOG`, 4096: watchdog cycles, 16-bit counter, for two cases: `tx_busy` failing to rise after `write_en`, and the owner stalling mid-packet.

Clock is `clk`. One clock domain. Reset is `reset`, synchronous and active-high.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte on its lane.
- `req_data`  in  8*NUM_REQ  byte lane i is `[8i+7:8i]`.
- `req_last`  in  NUM_REQ  the byte on lane i ends its packet.
- `req_ready`  out  NUM_REQ  one-cycle pulse; the lane-i byte is consumed on this edge.
- `tx_busy`  in  1  UART TX core is shifting a byte.
- `write_data`  out  8  byte to the UART core.
- `write_en`  out  1  one-cycle load strobe to the UART core.
- `grant`  out  NUM_REQ  one-hot current owner; 0 when idle.
- `busy`  out  1  a packet is in progress.
- `err_abort`  out  1  one-cycle pulse when a packet is aborted by the watchdog.

## Operation
- States:
  - IDLE
  - SEND: `write_en` cycle.
  - WAIT_HI: wait for `tx_busy` to rise.
  - WAIT_LO: wait for `tx_busy` to fall.
  - HOLD: owner has no valid byte.
- IDLE: if any `req_valid` is set, pick the winner round-robin, starting at `(last_owner+1) mod NUM_REQ`.
  - Register `grant`, `write_data` = winner lane, and `last_q` = winner `req_last`.
  - Go to SEND.
- SEND:
  - Assert `write_en` and `req_ready[owner]` for exactly this cycle.
  - Load the watchdog with `WDOG`.
  - Go to WAIT_HI.
- WAIT_HI: if `tx_busy`=1 or the watchdog reaches 0, go to WAIT_LO. A watchdog expiry here is not an error, because the UART core may be fast.
- WAIT_LO: when `tx_busy`=0:
  - If `last_q`: set `last_owner` to the owner, clear `grant`, go to IDLE.
  - Otherwise, if `req_valid[owner]`: latch data and `last_q`, go to SEND.
  - Otherwise: load the watchdog, go to HOLD.
- HOLD:
  - If `req_valid[owner]`: latch data and `last_q`, go to SEND.
  - If the watchdog reaches 0: pulse `err_abort`, set `last_owner` to the owner, clear `grant`, go to IDLE.
- No preemption. A non-owner `req_valid` is ignored until the grant is released. The owner's `req_valid` is ignored outside WAIT_LO and HOLD.
- `busy` = (state != IDLE).
- Reset mid-packet: the byte in flight is dropped and the UART core is not re-strobed. Requesters are expected to be reset by the same `reset`.
- Reset values:
  - `write_en`=0, `write_data`=0, `req_ready`=0, `grant`=0, `busy`=0, `err_abort`=0.
  - State IDLE.
  - `last_owner`=NUM_REQ-1, so lane 0 wins first.

## Timing
- `req_valid` sampled high in IDLE (cycle t) gives `write_en`, `req_ready` and the new `grant` at t+1.
- Inter-byte: `tx_busy` sampled 0 in WAIT_LO at cycle t, with the owner valid, gives `write_en` at t+1.
- After the `last` byte: `tx_busy` is sampled 0 at t, `grant`=0 at t+1, and a new arbitration fires at t+1, so the next `write_en` is at t+2.
- `write_data` is stable from the SEND cycle until the next SEND.
- `req_ready` and `write_en` are always coincident.
- Watchdog: the counter loads on entry and decrements each cycle. Expiry is the cycle its value is 0, i.e. `WDOG`+1 cycles after load.

## Structure
- Package `uart_arb_pkg` holds:
  - State encoding localparams (3-bit).
  - `WDOG_W`=16.
  - Default `NUM_REQ`.
- Sub-module `uart_rr_pick` is combinational: inputs `req` [NUM_REQ] and `last_owner`, outputs a one-hot winner and its index. It is reused by future DDR/status arbiters.
- Everything else, i.e. the FSM, watchdog and data/last latch, lives in `uart_tx_arbiter`.

## Test plan
- Single packet: lane 0 sends FF,FF,12,0D,0A with `last` on 0A, and the UART model holds `tx_busy` 10 cycles per byte → 5 `write_en` pulses in order, `grant`=001 throughout, `grant`=000 one cycle after the final fall.
- Contention: lanes 0, 1 and 2 all valid at t0 → packets served in order 0, 1, 2. After lane 2 finishes and lane 0 re-requests alongside lane 1, lane 0 wins (wrap). No byte interleaving.
- No preemption: lane 1 owns a 4-byte packet and lane 0 asserts valid mid-packet → lane 0's first `write_en` comes only after lane 1's `last` byte completes.
- Owner stall: `WDOG`=20, and lane 2 drops valid after its 2nd non-last byte → `err_abort` is pulsed exactly once 21 cycles into HOLD, `grant` is cleared, and the next arbitration starts at lane 0.
- Fast UART: `tx_busy` is tied 0 and `WDOG`=5 → each byte still gets exactly one `write_en`, spaced by 8 cycles (SEND + 6 WAIT_HI + 1 WAIT_LO), and `err_abort` stays 0.
- Reset mid-packet: `reset` is asserted for 1 cycle during WAIT_HI of byte 3 → every output is 0 the next cycle. No `write_en` follows until a new `req_valid`, which is then served from lane 0.
